upcounter_seq_monitor: RTL and testbench

Downstream consumer of the 3-bit mod-8 synchronous up counter outputs (Qc,Qb,Qa). Checks every sample for a legal +1 (mod 8) step or a legal hold, and detects terminal count (7->0 wrap). It extends the count with a wrap counter and flags sequence faults through a lock/error state machine. It shares clk and clr with the counter and sits directly on the counter's output bus.

---
 rtl/counter_pkg.sv | 19 +
 rtl/sat_counter.sv | 20 ++
 rtl/upcounter_seq_monitor.sv | 117 +++++++++++
 tb/tb_upcounter_seq_monitor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the 3-bit mod-8 up counter and its downstream sequence monitor.
package counter_pkg;

    localparam int              CNT_W   = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'b00,
        ST_LOCKED  = 2'b01,
        ST_ERROR   = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    // Successor of a counter value; the natural width truncation gives the mod-8 wrap.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] v);
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones instead of wrapping; used for the mismatch tally.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/upcounter_seq_monitor.sv
// Watches the mod-8 counter bus, checks each sample for a legal step or hold,
// extends the count with a wrap counter and tracks lock/fault state.
module upcounter_seq_monitor
    import counter_pkg::*;
#(
    parameter int WRAP_W = 5,
    parameter int ERR_W  = 4
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      Qa,
    input  logic                      Qb,
    input  logic                      Qc,
    input  logic                      cnt_en,
    input  logic                      resync,
    output logic                      tc,
    output logic [WRAP_W+CNT_W-1:0]   ext_count,
    output logic                      locked,
    output logic                      err,
    output logic [ERR_W-1:0]          err_cnt,
    output logic [1:0]                state
);

    logic [CNT_W-1:0]  q;
    logic [CNT_W-1:0]  prev;
    logic [CNT_W-1:0]  expected;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              step_ok;
    logic              wrap_hit;
    logic              mismatch;
    logic              tc_q;
    logic              err_q;
    state_t            state_q;
    state_t            state_d;

    assign q = {Qc, Qb, Qa};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        expected = cnt_en ? next_count(prev) : prev;
        step_ok  = (q == expected);
        wrap_hit = cnt_en && (prev == CNT_MAX) && (q == '0);
        mismatch = (state_q == ST_LOCKED) && !resync && !step_ok;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (resync) begin
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC:   if (cnt_en) state_d = ST_LOCKED;
                ST_LOCKED: if (!step_ok) state_d = ST_ERROR;
                ST_ERROR:  state_d = ST_ERROR;
                default:   state_d = ST_SYNC;
            endcase
        end
    end

    // In LOCKED prev follows q on both a legal step/hold and a fault, so it loads unconditionally.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prev     <= '0;
            wrap_cnt <= '0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (resync) begin
                wrap_cnt <= '0;
                err_q    <= 1'b0;
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        if (cnt_en) prev <= q;
                    end
                    ST_LOCKED: begin
                        prev <= q;
                        if (wrap_hit) begin
                            tc_q     <= 1'b1;
                            wrap_cnt <= wrap_cnt + 1'b1;
                        end
                        if (!step_ok) err_q <= 1'b1;
                    end
                    ST_ERROR: begin
                        prev <= q;
                    end
                    default: ;
                endcase
            end
        end
    end

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .clr   (clr),
        .inc   (mismatch),
        .count (err_cnt)
    );

    always_comb begin
        tc        = tc_q;
        err       = err_q;
        locked    = (state_q == ST_LOCKED);
        state     = state_q;
        ext_count = {wrap_cnt, prev};
    end

endmodule

// File: tb/tb_upcounter_seq_monitor.sv
// Randomised and directed bench for upcounter_seq_monitor against a behavioural model.
module tb_upcounter_seq_monitor;

    logic       clk = 1'b0;
    logic       clr;
    logic       Qa, Qb, Qc;
    logic       cnt_en;
    logic       resync;
    logic       tc;
    logic [7:0] ext_count;
    logic       locked;
    logic       err;
    logic [3:0] err_cnt;
    logic [1:0] state;

    int checks    = 0;
    int errors    = 0;
    int tc_pulses = 0;
    bit run_cmp   = 0;
    int cur;
    int last;

    // Behavioural model: mode 0=sync, 1=locked, 2=error.
    int m_mode, m_prev, m_wraps, m_errcnt, m_q, m_exp;
    bit m_err, m_tc;

    upcounter_seq_monitor #(.WRAP_W(5), .ERR_W(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .Qa        (Qa),
        .Qb        (Qb),
        .Qc        (Qc),
        .cnt_en    (cnt_en),
        .resync    (resync),
        .tc        (tc),
        .ext_count (ext_count),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit en, input int qv, input bit rs);
        @(negedge clk);
        #1;
        cnt_en      = en;
        {Qc, Qb, Qa} = 3'(qv);
        resync      = rs;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive(1'b1, cur, 1'b0);
            cur = (cur + 1) % 8;
        end
    endtask

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_mode = 0; m_prev = 0; m_wraps = 0; m_errcnt = 0; m_err = 0; m_tc = 0;
        end else begin
            m_q  = {Qc, Qb, Qa};
            m_tc = 0;
            if (resync) begin
                m_mode = 0; m_wraps = 0; m_err = 0;
            end else if (m_mode == 0) begin
                if (cnt_en) begin
                    m_prev = m_q;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                m_exp = cnt_en ? (m_prev + 1) % 8 : m_prev;
                if (m_q == m_exp) begin
                    if (cnt_en && m_q == 0) begin
                        m_tc    = 1;
                        m_wraps = (m_wraps + 1) % 32;
                    end
                end else begin
                    m_err    = 1;
                    m_errcnt = (m_errcnt < 15) ? m_errcnt + 1 : 15;
                    m_mode   = 2;
                end
                m_prev = m_q;
            end else begin
                m_prev = m_q;
            end
        end
    end

    always @(negedge clk) begin
        if (tc === 1'b1) tc_pulses++;
        if (run_cmp) begin
            check("tc", 32'(tc), 32'(m_tc));
            check("ext_count", 32'(ext_count), 32'(m_wraps * 8 + m_prev));
            check("locked", 32'(locked), 32'(m_mode == 1));
            check("err", 32'(err), 32'(m_err));
            check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
            check("state", 32'(state), 32'(m_mode));
        end
    end

    initial begin
        clr = 1'b1; cnt_en = 1'b0; resync = 1'b0; {Qc, Qb, Qa} = 3'd0;
        #3;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ext", 32'(ext_count), 32'd0);
        check("rst_flags", 32'({tc, locked, err}), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        #9;
        clr = 1'b0; cnt_en = 1'b1; {Qc, Qb, Qa} = 3'd0; cur = 1; run_cmp = 1;

        // Free-run through the first 7->0 wrap.
        run(8);
        @(posedge clk); #1;
        check("t1_tc", 32'(tc), 32'd1);
        check("t1_ext", 32'(ext_count), 32'h08);

        // Long free-run: wrap counter rolls over 31->0.
        run(264);
        @(posedge clk); #1;
        check("t2_ext", 32'(ext_count), 32'h10);
        check("t2_err", 32'(err), 32'd0);

        // Fault at prev=3, then resync and relock.
        run(3);
        drive(1'b1, 5, 1'b0);
        @(posedge clk); #1;
        check("t2_tc_pulses", 32'(tc_pulses), 32'd34);
        check("t3_state", 32'(state), 32'd2);
        check("t3_flags", 32'({err, locked, tc}), 32'b100);
        check("t3_err_cnt", 32'(err_cnt), 32'd1);
        drive(1'b0, 0, 1'b1);
        @(posedge clk); #1;
        check("t3_sync_state", 32'(state), 32'd0);
        check("t3_sync_ext", 32'(ext_count), 32'h05);
        drive(1'b1, 4, 1'b0);
        @(posedge clk); #1;
        check("t3_relock", 32'({locked, err}), 32'b10);
        check("t3_err_kept", 32'(err_cnt), 32'd1);
        check("t3_ext", 32'(ext_count), 32'h04);
        cur = 5;

        // Hold at 6 for four cycles, then step 6->7->0.
        run(2);
        repeat (4) drive(1'b0, 6, 1'b0);
        @(posedge clk); #1;
        check("t4_hold_ext", 32'(ext_count), 32'h06);
        check("t4_hold_err", 32'(err), 32'd0);
        drive(1'b1, 7, 1'b0);
        drive(1'b1, 0, 1'b0);
        @(posedge clk); #1;
        check("t4_tc", 32'(tc), 32'd1);
        check("t4_ext", 32'(ext_count), 32'h08);
        cur = 1;

        // Twenty faults with resync between: err_cnt saturates.
        repeat (20) begin
            drive(1'b1, (cur + 2) % 8, 1'b0);
            drive(1'b0, 0, 1'b1);
            drive(1'b1, 0, 1'b0);
        end
        @(posedge clk); #1;
        check("t5_sat", 32'(err_cnt), 32'd15);
        check("t5_locked", 32'(locked), 32'd1);
        cur = 1;

        // Async clear just before a 7->0 wrap would be sampled.
        run(7);
        @(negedge clk); #1;
        cnt_en = 1'b1; {Qc, Qb, Qa} = 3'd0; resync = 1'b0;
        #2 clr = 1'b1;
        #1;
        check("t6_async_ext", 32'(ext_count), 32'd0);
        check("t6_async_flags", 32'({tc, locked, err}), 32'd0);
        check("t6_async_state", 32'(state), 32'd0);
        check("t6_async_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        check("t6_no_tc", 32'(tc), 32'd0);
        @(negedge clk); #1;
        clr = 1'b0; cnt_en = 1'b1; {Qc, Qb, Qa} = 3'd3;
        @(posedge clk); #1;
        check("t6_relock", 32'(locked), 32'd1);
        check("t6_ext", 32'(ext_count), 32'h03);

        // Randomised phase: mostly legal steps/holds, occasional corruption and resync.
        last = 3;
        for (int i = 0; i < 400; i++) begin
            bit en;
            bit rs;
            int qv;
            en = ($urandom % 4) != 0;
            rs = ($urandom % 40) == 0;
            qv = en ? (last + 1) % 8 : last;
            if (($urandom % 16) == 0) qv = $urandom % 8;
            drive(en, qv, rs);
            last = qv;
        end
        @(negedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
